// File: rtl/sdram_bus_bridge_if.sv
// sdram_bus_bridge_if: bundles the CPU word bus and the SDRAM controller
// halfword command bus seen by sdram_bus_bridge.
//   master : the environment side (CPU requester plus SDRAM controller status)
//   slave  : the bridge itself
interface sdram_bus_bridge_if #(
    parameter int unsigned ADDR_W    = 23,
    parameter int unsigned HW_ADDR_W = 22
);
    // CPU side
    logic                 sel;
    logic [ADDR_W-1:0]    addr;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 ready;
    logic [31:0]          rdata;

    // SDRAM controller side
    logic [HW_ADDR_W-1:0] wr_addr;
    logic [HW_ADDR_W-1:0] rd_addr;
    logic [15:0]          wr_data;
    logic                 wr_enable;
    logic                 rd_enable;
    logic [15:0]          rd_data;
    logic                 rd_ready;
    logic                 busy;

    modport master (
        output sel, addr, wdata, wstrb,
        input  ready, rdata,
        input  wr_addr, rd_addr, wr_data, wr_enable, rd_enable,
        output rd_data, rd_ready, busy
    );

    modport slave (
        input  sel, addr, wdata, wstrb,
        output ready, rdata,
        output wr_addr, rd_addr, wr_data, wr_enable, rd_enable,
        input  rd_data, rd_ready, busy
    );
endinterface

// File: rtl/sdram_bus_bridge.sv
// sdram_bus_bridge: converts 32-bit CPU word accesses into two 16-bit SDRAM
// controller commands (halfword 0 = bytes 1:0, then halfword 1 = bytes 3:2).
// Halfwords with no strobes in a write are skipped entirely.
//
// Optional feature: define SDRAM_BRIDGE_RMW_EN to turn single-byte halfword
// writes into read-merge-write sequences that preserve the unstrobed byte.
// Without it, such halfwords are written whole from wdata.
module sdram_bus_bridge #(
    parameter int unsigned ADDR_W    = 23,
    parameter int unsigned HW_ADDR_W = 22
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    sdram_bus_bridge_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] ACCEPT = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] RESP   = 3'd5;
`ifdef SDRAM_BRIDGE_RMW_EN
    localparam logic [2:0] MERGE  = 3'd4;
`endif

    logic [2:0]           state;
    logic                 hw;
    logic [ADDR_W-3:0]    addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic                 cur_rd;      // command in flight is a read
    logic [15:0]          hw0_data;

    logic                 ready_q;
    logic [31:0]          rdata_q;
    logic                 wr_en_q;
    logic                 rd_en_q;
    logic [HW_ADDR_W-1:0] wr_addr_q;
    logic [HW_ADDR_W-1:0] rd_addr_q;
    logic [15:0]          wr_data_q;

`ifdef SDRAM_BRIDGE_RMW_EN
    logic [15:0]          rmw_q;       // halfword read back for merging
    logic [15:0]          merge_q;     // merged halfword to be written
    logic                 merged;      // current halfword already read+merged
`endif

    logic [1:0]           cur_strb;
    logic [15:0]          cur_wdata;
    logic                 is_read;
    logic                 skip_hw;
    logic                 need_rd;
    logic [15:0]          wr_half;
    logic [HW_ADDR_W-1:0] hw_addr;
    logic                 hw_done;

    // Word address lsbs are ignored: accesses are always word aligned.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.addr[1:0];

    // Decode what the current halfword needs from the latched request.
    always_comb begin
        cur_strb  = hw ? wstrb_q[3:2] : wstrb_q[1:0];
        cur_wdata = hw ? wdata_q[31:16] : wdata_q[15:0];
        is_read   = (wstrb_q == 4'b0000);
        skip_hw   = !is_read && (cur_strb == 2'b00);
        hw_addr   = HW_ADDR_W'({addr_q, hw});
`ifdef SDRAM_BRIDGE_RMW_EN
        need_rd   = is_read || ((^cur_strb) && !merged);
        wr_half   = merged ? merge_q : cur_wdata;
`else
        need_rd   = is_read;
        wr_half   = cur_wdata;
`endif
    end

    // Flag the cycle in which the current halfword is finished.
    always_comb begin
        hw_done = 1'b0;
        case (state)
            ISSUE:   hw_done = skip_hw;
            WAIT:    hw_done = cur_rd ? (bus.rd_ready && is_read) : !bus.busy;
            default: hw_done = 1'b0;
        endcase
    end

    // Main sequencer: latch request, issue per-halfword commands, respond.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hw        <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cur_rd    <= 1'b0;
            hw0_data  <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
`ifdef SDRAM_BRIDGE_RMW_EN
            rmw_q     <= '0;
            merge_q   <= '0;
            merged    <= 1'b0;
`endif
        end else begin
            // Command enables and ready are single-cycle pulses.
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            ready_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.sel) begin
                        addr_q  <= bus.addr[ADDR_W-1:2];
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb;
                        hw      <= 1'b0;
`ifdef SDRAM_BRIDGE_RMW_EN
                        merged  <= 1'b0;
`endif
                        state   <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (!skip_hw && !bus.busy) begin
                        if (need_rd) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= hw_addr;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= hw_addr;
                            wr_data_q <= wr_half;
                        end
                        cur_rd <= need_rd;
                        state  <= ACCEPT;
                    end
                end

                // Controller acknowledges a command by raising busy.
                ACCEPT: begin
                    if (bus.busy) begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (cur_rd && bus.rd_ready) begin
                        if (is_read) begin
                            if (!hw) begin
                                hw0_data <= bus.rd_data;
                            end else begin
                                rdata_q <= {bus.rd_data, hw0_data};
                            end
                        end
`ifdef SDRAM_BRIDGE_RMW_EN
                        else begin
                            rmw_q <= bus.rd_data;
                            state <= MERGE;
                        end
`endif
                    end
                end

`ifdef SDRAM_BRIDGE_RMW_EN
                // Replace only the strobed byte, keep the other from memory.
                MERGE: begin
                    merge_q <= cur_strb[0] ? {rmw_q[15:8], cur_wdata[7:0]}
                                           : {cur_wdata[15:8], rmw_q[7:0]};
                    merged  <= 1'b1;
                    state   <= ISSUE;
                end
`endif

                // sel is deliberately ignored here; a new access starts in IDLE.
                RESP: begin
                    rdata_q <= '0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase

            // Halfword completion overrides the per-state next state above.
            if (hw_done) begin
                if (!hw) begin
                    hw    <= 1'b1;
`ifdef SDRAM_BRIDGE_RMW_EN
                    merged <= 1'b0;
`endif
                    state <= ISSUE;
                end else begin
                    ready_q <= 1'b1;
                    state   <= RESP;
                end
            end
        end
    end

    assign bus.ready     = ready_q;
    assign bus.rdata     = rdata_q;
    assign bus.wr_enable = wr_en_q;
    assign bus.rd_enable = rd_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// tb_sdram_bus_bridge: randomized + directed scoreboard bench for the bridge.
// A reference model derives the expected controller commands and CPU response
// from word-level rules; a controller model with its own memory answers the
// bridge; monitors pop and compare on every command and every ready pulse.
module tb_sdram_bus_bridge;

    localparam int unsigned ADDR_W    = 23;
    localparam int unsigned HW_ADDR_W = 22;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk_sys = ~clk_sys;

    sdram_bus_bridge_if #(.ADDR_W(ADDR_W), .HW_ADDR_W(HW_ADDR_W)) bif ();

    sdram_bus_bridge #(.ADDR_W(ADDR_W), .HW_ADDR_W(HW_ADDR_W)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bif)
    );

    typedef struct {
        bit          is_wr;
        int unsigned ha;
        logic [15:0] data;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_resp[$];

    logic [15:0] ref_mem [int unsigned];
    logic [15:0] ctl_mem [int unsigned];

    int total = 0;
    int bad = 0;
    int resp_count = 0;
    int en_count = 0;
    int lat_override = 0;
    logic ctl_busy = 1'b0;
    logic hog = 1'b0;

    assign bif.busy = ctl_busy | hog;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input int unsigned ha);
        return 16'((ha * 32'h9E37) ^ 32'h5A5A);
    endfunction

    function automatic logic [15:0] ref_get(input int unsigned ha);
        return ref_mem.exists(ha) ? ref_mem[ha] : init_val(ha);
    endfunction

    function automatic logic [15:0] ctl_get(input int unsigned ha);
        return ctl_mem.exists(ha) ? ctl_mem[ha] : init_val(ha);
    endfunction

    task automatic preload(input int unsigned ha, input logic [15:0] v);
        ref_mem[ha] = v;
        ctl_mem[ha] = v;
    endtask

    // Reference model: expected commands and response for one word access.
    task automatic model_push(input logic [22:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned base;
        logic [31:0] rsp;
        base = 32'(a[22:2]) << 1;
        rsp = 32'h0;
        for (int k = 0; k < 2; k++) begin
            int unsigned ha;
            logic [1:0]  st;
            logic [15:0] dh;
            logic [15:0] old;
            ha  = base + 32'(k);
            st  = (k == 1) ? s[3:2] : s[1:0];
            dh  = (k == 1) ? d[31:16] : d[15:0];
            old = ref_get(ha);
            if (s == 4'h0) begin
                exp_cmd.push_back('{is_wr: 1'b0, ha: ha, data: 16'h0});
                if (k == 1) rsp[31:16] = old; else rsp[15:0] = old;
            end else if (st == 2'b11) begin
                exp_cmd.push_back('{is_wr: 1'b1, ha: ha, data: dh});
                ref_mem[ha] = dh;
            end else if (st != 2'b00) begin
`ifdef SDRAM_BRIDGE_RMW_EN
                logic [15:0] m;
                m = st[0] ? {old[15:8], dh[7:0]} : {dh[15:8], old[7:0]};
                exp_cmd.push_back('{is_wr: 1'b0, ha: ha, data: 16'h0});
                exp_cmd.push_back('{is_wr: 1'b1, ha: ha, data: m});
                ref_mem[ha] = m;
`else
                exp_cmd.push_back('{is_wr: 1'b1, ha: ha, data: dh});
                ref_mem[ha] = dh;
`endif
            end
        end
        exp_resp.push_back(rsp);
    endtask

    task automatic scramble();
        bif.addr  = 23'($urandom);
        bif.wdata = $urandom;
        bif.wstrb = 4'($urandom);
    endtask

    // Drive one request; hold keeps sel high until one cycle past ready.
    task automatic drive_and_wait(input logic [22:0] a, input logic [31:0] d,
                                  input logic [3:0] s, input bit hold);
        bit got;
        @(negedge clk_sys);
        bif.sel   = 1'b1;
        bif.addr  = a;
        bif.wdata = d;
        bif.wstrb = s;
        if (!hold) begin
            @(negedge clk_sys);
            bif.sel = 1'b0;
            scramble();
        end
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk_sys);
            if (hold) scramble();
            if (bif.ready) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got no ready, want ready within 400 cycles");
        end
        if (hold) begin
            @(negedge clk_sys);
            bif.sel = 1'b0;
        end
    endtask

    task automatic do_txn(input logic [22:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit hold);
        model_push(a, d, s);
        drive_and_wait(a, d, s, hold);
    endtask

    // SDRAM controller model: busy for a few cycles per command, rd_ready on the last.
    initial begin
        int cnt;
        bit rd_op;
        int unsigned ha;
        cnt = 0;
        rd_op = 1'b0;
        ha = 0;
        bif.rd_ready = 1'b0;
        bif.rd_data  = 16'h0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                cnt = 0;
                ctl_busy = 1'b0;
                bif.rd_ready = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 1 && rd_op) begin
                    bif.rd_ready = 1'b1;
                    bif.rd_data  = ctl_get(ha);
                end else if (cnt == 0) begin
                    ctl_busy = 1'b0;
                    bif.rd_ready = 1'b0;
                    bif.rd_data  = 16'($urandom);
                end
            end else if (bif.wr_enable || bif.rd_enable) begin
                rd_op = bif.rd_enable;
                ha = bif.rd_enable ? 32'(bif.rd_addr) : 32'(bif.wr_addr);
                if (bif.wr_enable) ctl_mem[ha] = bif.wr_data;
                cnt = (lat_override != 0) ? lat_override : int'($urandom_range(2, 5));
                ctl_busy = 1'b1;
            end else begin
                bif.rd_data = 16'($urandom);
            end
        end
    end

    // Scoreboard monitor: commands and responses checked as they appear.
    initial begin
        logic prev_ready;
        cmd_t c;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (reset_n) begin
                if (bif.wr_enable || bif.rd_enable) begin
                    en_count++;
                    check("enable_exclusive", 64'(bif.wr_enable & bif.rd_enable), 64'h0);
                    if (exp_cmd.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_cmd: got wr=%0b rd=%0b wa=0x%0h ra=0x%0h, want none",
                                 bif.wr_enable, bif.rd_enable, bif.wr_addr, bif.rd_addr);
                    end else begin
                        c = exp_cmd.pop_front();
                        check("cmd_is_write", 64'(bif.wr_enable), 64'(c.is_wr));
                        check("cmd_addr", 64'(bif.wr_enable ? bif.wr_addr : bif.rd_addr), 64'(c.ha));
                        if (c.is_wr) check("cmd_wdata", 64'(bif.wr_data), 64'(c.data));
                    end
                end
                if (bif.ready) begin
                    resp_count++;
                    check("ready_one_cycle", 64'(prev_ready), 64'h0);
                    if (exp_resp.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ready: got rdata=0x%0h, want no ready", bif.rdata);
                    end else begin
                        check("rdata", 64'(bif.rdata), 64'(exp_resp.pop_front()));
                    end
                end
            end
            prev_ready = bif.ready;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before 1000000");
        $fatal(1);
    end

    initial begin
        int e0;
        int r0;
        bit seen;
        bif.sel = 1'b0;
        scramble();
        hog = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("reset_ready", 64'(bif.ready), 64'h0);
        check("reset_rdata", 64'(bif.rdata), 64'h0);
        check("reset_enables", 64'({bif.wr_enable, bif.rd_enable}), 64'h0);
        check("reset_wr_addr", 64'(bif.wr_addr), 64'h0);
        check("reset_rd_addr", 64'(bif.rd_addr), 64'h0);
        check("reset_wr_data", 64'(bif.wr_data), 64'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Word read split into two halfword reads
        preload(32'h8, 16'h1234);
        preload(32'h9, 16'hABCD);
        do_txn(23'h000010, $urandom, 4'h0, 1'b0);
        // Full word write
        do_txn(23'h000020, 32'hDEADBEEF, 4'hF, 1'b0);
        // Upper halfword only: no hw=0 command
        do_txn(23'h000030, 32'h55660000, 4'hC, 1'b0);
        // Single byte strobe in hw=0, hw=1 skipped
        preload(32'h20, 16'h1234);
        do_txn(23'h000040, 32'h000000AA, 4'h1, 1'b0);
        do_txn(23'h000040, 32'h0, 4'h0, 1'b1);

        // Controller busy for 20 cycles while the bridge wants to issue
        @(negedge clk_sys);
        hog = 1'b1;
        #1;
        e0 = en_count;
        model_push(23'h000060, 32'h0000C0DE, 4'h3);
        @(negedge clk_sys);
        bif.sel = 1'b1;
        bif.addr = 23'h000060;
        bif.wdata = 32'h0000C0DE;
        bif.wstrb = 4'h3;
        @(negedge clk_sys);
        bif.sel = 1'b0;
        scramble();
        repeat (20) @(negedge clk_sys);
        #1;
        check("busy_hold_no_enable", 64'(en_count - e0), 64'h0);
        hog = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_sys);
            if (bif.ready) seen = 1'b1;
        end
        #1;
        check("busy_release_ready", 64'(seen), 64'h1);
        check("busy_release_one_enable", 64'(en_count - e0), 64'h1);

        // Reset while waiting on a read
        lat_override = 8;
        exp_cmd.push_back('{is_wr: 1'b0, ha: 32'h40, data: 16'h0});
        @(negedge clk_sys);
        bif.sel = 1'b1;
        bif.addr = 23'h000080;
        bif.wstrb = 4'h0;
        @(negedge clk_sys);
        bif.sel = 1'b0;
        scramble();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_sys);
            if (bif.rd_enable) seen = 1'b1;
        end
        check("abort_read_issued", 64'(seen), 64'h1);
        @(posedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_ready", 64'(bif.ready), 64'h0);
        check("abort_enables", 64'({bif.wr_enable, bif.rd_enable}), 64'h0);
        check("abort_rd_addr", 64'(bif.rd_addr), 64'h0);
        check("abort_rdata", 64'(bif.rdata), 64'h0);
        r0 = resp_count;
        e0 = en_count;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (12) @(negedge clk_sys);
        #1;
        check("abort_no_ready", 64'(resp_count - r0), 64'h0);
        check("abort_no_cmd", 64'(en_count - e0), 64'h0);
        lat_override = 0;

        // Randomized traffic over a small address window to reuse locations
        for (int n = 0; n < 80; n++) begin
            logic [22:0] a;
            logic [3:0]  s;
            a = 23'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) a = 23'($urandom);
            case ($urandom_range(0, 3))
                0:       s = 4'h0;
                1:       s = 4'hF;
                default: s = 4'($urandom);
            endcase
            do_txn(a, $urandom, s, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        end

        repeat (10) @(negedge clk_sys);
        check("cmd_queue_drained", 64'(exp_cmd.size()), 64'h0);
        check("resp_queue_drained", 64'(exp_resp.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
